adc_spi_emulator: RTL and testbench
===================================

# adc_spi_emulator

Synthesizable SPI responder that stands in for one 10-bit serial ADC so the acquisition chain (SPI capture, ring buffer, trigger FFT, cross-correlation) can be exercised on hardware without the analog front end. It answers the chip-select / serial-clock frame issued by the SPI capture block with 16-bit ADC-format frames, sourcing samples from a small FIFO loaded by a pattern generator or host. One instance per emulated channel.

## Interface
- DATA_W, 10, sample width in bits
- LEAD_ZEROS, 3, zero bits preceding sample MSB in each frame
- FRAME_BITS, 16, SCLK falling edges per frame (must be ≥ LEAD_ZEROS+DATA_W)
- DEPTH, 4, sample FIFO entries (power of 2)

- clk  in  1  system clock; all logic on rising edge; must be ≥ 8× SPI_clk frequency
- reset  in  1  synchronous, active-high reset
- SPI_clk  in  1  serial clock from SPI master, asynchronous to clk
- cs_n  in  1  chip select from master, active low, asynchronous to clk
- sample_in  in  DATA_W  sample to enqueue
- sample_valid  in  1  sample_in valid
- sample_ready  out  1  FIFO not full
- sdo  out  1  serial data to master
- frame_done  out  1  one-cycle pulse on completion of a full frame
- frame_abort  out  1  one-cycle pulse when cs_n rises mid-frame
- underrun  out  1  one-cycle pulse when a frame starts with FIFO empty

## Operation
- SPI_clk and cs_n each pass a 2-FF synchronizer, then a registered edge detector; all protocol logic uses synchronized edges only.
- FIFO: write when sample_valid & sample_ready; pop only at frame start. Simultaneous push and pop on a full FIFO allowed (count unchanged); sample_ready reflects count before that cycle's pop.
- Frame start (synced cs_n falling): load shift register with FIFO head and pop; if empty, reload last transmitted sample (0 after reset) and pulse underrun. Bit counter n := 0; sdo := bit 0.
- Frame bit n (0..FRAME_BITS-1): 0 for n < LEAD_ZEROS; sample[DATA_W-1-(n-LEAD_ZEROS)] for LEAD_ZEROS ≤ n < LEAD_ZEROS+DATA_W; 0 otherwise.
- Each synced SPI_clk falling edge while in SHIFT: n := n+1, sdo := bit n. Rising edges ignored (master samples on them).
- States: IDLE (cs_n high, sdo=0) → SHIFT on cs_n fall. SHIFT → DONE on falling edge number FRAME_BITS (sdo := 0, pulse frame_done). SHIFT → IDLE on cs_n rise (pulse frame_abort; popped sample discarded). DONE → IDLE on cs_n rise; further SCLK edges in DONE ignored, sdo held 0.
- cs_n fall and SCLK falling edge detected same cycle: frame start wins, SCLK edge ignored.
- cs_n rise and FRAME_BITS-th falling edge same cycle: frame_done pulses, no frame_abort, → IDLE.
- Reset: FIFO emptied, last sample := 0, state IDLE, n := 0. Reset mid-frame abandons frame without frame_abort.

## Timing
- Reset values: sdo=0, sample_ready=1, frame_done=0, frame_abort=0, underrun=0.
- Pin-to-sdo latency: sdo changes on the 3rd clk rising edge after the edge that first samples the new SPI_clk/cs_n level (2 sync + 1 edge detect), all outputs registered.
- Half-period of SPI_clk ≥ 4 clk guarantees sdo settled before master's next rising edge.
- sample_ready updates the cycle after a push/pop; underrun and frame_start share the cycle of the sdo bit-0 update.
- No combinational path from any input to any output.

## Test plan
- Reset, push 0x2A5, drop cs_n, 16 SPI_clk cycles at clk/8 -> master sees 000_1010100101_000; frame_done pulses once; sample_ready=1 after pop.
- Push 0x3FF, 0x001, 0x200, 0x155 then 4 back-to-back frames -> samples read in order; 5th push while full blocked (sample_ready=0 until first pop).
- Frame with FIFO empty after reset -> underrun pulse, data 0x000; push 0x0F0, read, then empty frame -> 0x0F0 repeated, underrun pulses.
- Raise cs_n after 7 falling edges with 0x155 loaded -> frame_abort pulse, no frame_done, next frame returns next FIFO entry not 0x155.
- Extra SCLK edges after 16th (DONE) -> sdo stays 0, no second frame_done; assert reset mid-frame -> sdo=0, FIFO empty, no pulses.
- cs_n rise coincident with 16th synced falling edge -> frame_done only; cs_n fall coincident with SCLK fall -> bit 0 held, counter not advanced.

Source files
------------

// File: rtl/adc_spi_emulator.sv
// rtl/adc_spi_emulator.sv - SPI responder emulating a serial ADC, fed from a small sample FIFO
module adc_spi_emulator #(
    parameter int DATA_W     = 10,
    parameter int LEAD_ZEROS = 3,
    parameter int FRAME_BITS = 16,
    parameter int DEPTH      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SPI_clk,
    input  logic              cs_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              sdo,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              underrun
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic              sclk_meta_q, sclk_sync_q, sclk_prev_q, sclk_fall_q;
    logic              cs_meta_q, cs_sync_q, cs_prev_q, cs_fall_q, cs_rise_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              ready_q;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [DATA_W-1:0] shift_q, shift_d, last_q, last_d;
    logic              sdo_q, sdo_d, done_q, done_d, abort_q, abort_d, under_q, under_d;
    logic              push, pop, fifo_empty;
    logic [DATA_W-1:0] start_sample;

    function automatic logic frame_bit(input logic [DATA_W-1:0] s, input logic [CNT_W-1:0] n);
        int                idx;
        logic [DATA_W-1:0] t;
        idx = int'(n) - LEAD_ZEROS;
        t   = s << idx;
        if (idx >= 0 && idx < DATA_W) return t[DATA_W-1];
        return 1'b0;
    endfunction

    // Two-flop synchronizers followed by registered edge detectors.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
        end else begin
            sclk_meta_q <= SPI_clk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            sclk_fall_q <= sclk_prev_q & ~sclk_sync_q;
            cs_meta_q   <= cs_n;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            cs_fall_q   <= cs_prev_q & ~cs_sync_q;
            cs_rise_q   <= ~cs_prev_q & cs_sync_q;
        end
    end

    assign push         = sample_valid & ready_q;
    assign fifo_empty   = (count_q == '0);
    assign start_sample = fifo_empty ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= sample_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ready_q <= (count_d != (AW+1)'(DEPTH));
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        shift_d = shift_q;
        last_d  = last_q;
        sdo_d   = sdo_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        under_d = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                sdo_d = 1'b0;
                if (cs_fall_q) begin
                    state_d = SHIFT;
                    shift_d = start_sample;
                    last_d  = start_sample;
                    pop     = ~fifo_empty;
                    under_d = fifo_empty;
                    n_d     = '0;
                    sdo_d   = frame_bit(start_sample, '0);
                end
            end
            SHIFT: begin
                // Final falling edge takes precedence over a coincident cs_n rise.
                if (sclk_fall_q && n_q == CNT_W'(FRAME_BITS - 1)) begin
                    done_d  = 1'b1;
                    sdo_d   = 1'b0;
                    state_d = cs_rise_q ? IDLE : DONE;
                end else if (cs_rise_q) begin
                    abort_d = 1'b1;
                    sdo_d   = 1'b0;
                    state_d = IDLE;
                end else if (sclk_fall_q) begin
                    n_d   = n_q + 1'b1;
                    sdo_d = frame_bit(shift_q, n_q + 1'b1);
                end
            end
            DONE: begin
                sdo_d = 1'b0;
                if (cs_rise_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            shift_q <= '0;
            last_q  <= '0;
            sdo_q   <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            sdo_q   <= sdo_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            under_q <= under_d;
        end
    end

    assign sample_ready = ready_q;
    assign sdo          = sdo_q;
    assign frame_done   = done_q;
    assign frame_abort  = abort_q;
    assign underrun     = under_q;
endmodule

// File: tb/tb_adc_spi_emulator.sv
// tb/tb_adc_spi_emulator.sv - directed self-checking bench for adc_spi_emulator
module tb_adc_spi_emulator;
    logic       clk = 1'b0;
    logic       reset, SPI_clk, cs_n, sample_valid;
    logic [9:0] sample_in;
    logic       sample_ready, sdo, frame_done, frame_abort, underrun;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0, abort_cnt = 0, under_cnt = 0;
    int d0, a0, u0;
    logic [15:0] word;
    logic        extra;

    adc_spi_emulator dut (
        .clk          (clk),
        .reset        (reset),
        .SPI_clk      (SPI_clk),
        .cs_n         (cs_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sdo          (sdo),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
        if (underrun)    under_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [9:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        wait_clk(1);
        sample_valid = 1'b0;
        wait_clk(1);
    endtask

    task automatic snap();
        d0 = done_cnt;
        a0 = abort_cnt;
        u0 = under_cnt;
    endtask

    // Mode-0 master at clk/8: samples sdo on SPI_clk rise, bit 0 lands in word[15].
    task automatic frame(input int nbits, input int nextra, input bit coin_start,
                         input bit coin_end, output logic [15:0] w, output logic ex);
        w  = '0;
        ex = 1'b0;
        if (coin_start) begin
            SPI_clk = 1'b1;
            wait_clk(8);
            cs_n    = 1'b0;
            SPI_clk = 1'b0;
        end else begin
            cs_n = 1'b0;
        end
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            SPI_clk   = 1'b1;
            w[15 - i] = sdo;
            wait_clk(4);
            SPI_clk = 1'b0;
            if (coin_end && i == nbits - 1) cs_n = 1'b1;
            wait_clk(4);
        end
        for (int j = 0; j < nextra; j++) begin
            SPI_clk = 1'b1;
            ex      = ex | sdo;
            wait_clk(4);
            SPI_clk = 1'b0;
            wait_clk(4);
            ex      = ex | sdo;
        end
        cs_n = 1'b1;
        wait_clk(8);
    endtask

    initial begin
        reset        = 1'b1;
        SPI_clk      = 1'b0;
        cs_n         = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(2);
        chk("reset_sdo",   16'(sdo),          16'h0);
        chk("reset_ready", 16'(sample_ready), 16'h1);
        chk("reset_done",  16'(frame_done),   16'h0);
        chk("reset_abort", 16'(frame_abort),  16'h0);
        chk("reset_under", 16'(underrun),     16'h0);

        push(10'h2A5);
        snap();
        frame(16, 0, 0, 0, word, extra);
        chk("f2a5_word",  word, 16'h1528);
        chk("f2a5_done",  16'(done_cnt - d0), 16'h1);
        chk("f2a5_under", 16'(under_cnt - u0), 16'h0);
        chk("f2a5_ready", 16'(sample_ready), 16'h1);

        push(10'h3FF);
        push(10'h001);
        push(10'h200);
        push(10'h155);
        chk("full_ready", 16'(sample_ready), 16'h0);
        push(10'h111);
        chk("full_blocked", 16'(sample_ready), 16'h0);
        snap();
        frame(16, 0, 0, 0, word, extra);
        chk("q0_word",  word, 16'h1FF8);
        chk("q0_ready", 16'(sample_ready), 16'h1);
        frame(16, 0, 0, 0, word, extra);
        chk("q1_word", word, 16'h0008);
        frame(16, 0, 0, 0, word, extra);
        chk("q2_word", word, 16'h1000);
        frame(16, 0, 0, 0, word, extra);
        chk("q3_word", word, 16'h0AA8);
        chk("q_done",  16'(done_cnt - d0), 16'h4);
        chk("q_under", 16'(under_cnt - u0), 16'h0);
        frame(16, 0, 0, 0, word, extra);
        chk("q_empty_word",  word, 16'h0AA8);
        chk("q_empty_under", 16'(under_cnt - u0), 16'h1);

        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(2);
        snap();
        frame(16, 0, 0, 0, word, extra);
        chk("rst_empty_word",  word, 16'h0000);
        chk("rst_empty_under", 16'(under_cnt - u0), 16'h1);
        push(10'h0F0);
        snap();
        frame(16, 0, 0, 0, word, extra);
        chk("f0f0_word",  word, 16'h0780);
        chk("f0f0_under", 16'(under_cnt - u0), 16'h0);
        frame(16, 0, 0, 0, word, extra);
        chk("rep_word",  word, 16'h0780);
        chk("rep_under", 16'(under_cnt - u0), 16'h1);

        push(10'h155);
        push(10'h2A5);
        snap();
        frame(7, 0, 0, 0, word, extra);
        chk("abort_word",  word, 16'h0A00);
        chk("abort_pulse", 16'(abort_cnt - a0), 16'h1);
        chk("abort_done",  16'(done_cnt - d0), 16'h0);
        frame(16, 0, 0, 0, word, extra);
        chk("after_abort_word",  word, 16'h1528);
        chk("after_abort_under", 16'(under_cnt - u0), 16'h0);

        push(10'h3FF);
        snap();
        frame(16, 3, 0, 0, word, extra);
        chk("extra_word", word, 16'h1FF8);
        chk("extra_sdo",  16'(extra), 16'h0);
        chk("extra_done", 16'(done_cnt - d0), 16'h1);

        push(10'h3FF);
        snap();
        cs_n = 1'b0;
        wait_clk(4);
        for (int k = 0; k < 3; k++) begin
            SPI_clk = 1'b1;
            wait_clk(4);
            SPI_clk = 1'b0;
            wait_clk(4);
        end
        reset   = 1'b1;
        cs_n    = 1'b1;
        SPI_clk = 1'b0;
        wait_clk(6);
        reset = 1'b0;
        wait_clk(6);
        chk("midrst_sdo",    16'(sdo), 16'h0);
        chk("midrst_ready",  16'(sample_ready), 16'h1);
        chk("midrst_pulses", 16'((done_cnt - d0) + (abort_cnt - a0) + (under_cnt - u0)), 16'h0);
        frame(16, 0, 0, 0, word, extra);
        chk("midrst_word",  word, 16'h0000);
        chk("midrst_under", 16'(under_cnt - u0), 16'h1);

        push(10'h2A5);
        snap();
        frame(16, 0, 0, 1, word, extra);
        chk("coin_end_word",  word, 16'h1528);
        chk("coin_end_done",  16'(done_cnt - d0), 16'h1);
        chk("coin_end_abort", 16'(abort_cnt - a0), 16'h0);
        chk("coin_end_idle",  16'(sdo), 16'h0);

        push(10'h3FF);
        snap();
        frame(16, 0, 1, 0, word, extra);
        chk("coin_start_word",  word, 16'h1FF8);
        chk("coin_start_done",  16'(done_cnt - d0), 16'h1);
        chk("coin_start_under", 16'(under_cnt - u0), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
